// File: rtl/network_barrier.sv
// Barrier that starts a network of triggers, aggregates their idle/sleep/sync state and
// reports completion. Optional watchdog forced-finish: define NETWORK_BARRIER_WATCHDOG_EN.
module network_barrier #(
  parameter int unsigned NUM_ACTORS     = 4,
  parameter int unsigned NUM_INPUTS     = 1,
  parameter int unsigned WATCHDOG_LIMIT = 65535
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_ready,
  output logic                  ap_idle,
  output logic                  actor_ap_start,
  input  logic [NUM_ACTORS-1:0] actor_ap_idle,
  input  logic [NUM_ACTORS-1:0] actor_sleep,
  input  logic [NUM_ACTORS-1:0] actor_sync_exec,
  input  logic [NUM_ACTORS-1:0] actor_sync_wait,
  input  logic [NUM_INPUTS-1:0] in_fifo_write,
  output logic                  all_sleep,
  output logic                  all_sync,
  output logic                  all_sync_wait,
  output logic                  external_enqueue,
  output logic [15:0]           round_count,
  output logic                  watchdog_trip
);

  typedef enum logic [1:0] {StIdle, StStart, StRun, StFinish} state_e;

  state_e      state_q, state_d;
  logic        seen_busy_q, seen_busy_d;
  logic        ext_q, ext_d;
  logic        sync_prev_q;
  logic [15:0] round_q, round_d;
  logic        in_run;
  logic        sync_rise;
  logic        wd_fire;

  assign in_run        = (state_q == StRun);
  assign all_sleep     = in_run & (&actor_sleep);
  assign all_sync      = in_run & (&(actor_sync_exec | actor_sync_wait));
  assign all_sync_wait = in_run & (&actor_sync_wait);
  assign sync_rise     = all_sync & ~sync_prev_q;

  assign ap_idle          = (state_q == StIdle);
  assign actor_ap_start   = (state_q == StStart);
  assign ap_done          = (state_q == StFinish);
  assign ap_ready         = ap_done;
  assign external_enqueue = ext_q & in_run;
  assign round_count      = round_q;

`ifdef NETWORK_BARRIER_WATCHDOG_EN
  logic [31:0] wd_cnt_q, wd_cnt_d;
  logic        trip_q, trip_d;

  assign wd_fire       = in_run & (wd_cnt_q == 32'(WATCHDOG_LIMIT));
  assign watchdog_trip = trip_q;

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    trip_d   = trip_q;
    if (state_q == StStart) begin
      wd_cnt_d = '0;
      trip_d   = 1'b0;
    end else if (in_run) begin
      wd_cnt_d = sync_rise ? '0 : wd_cnt_q + 32'd1;
      if (wd_fire) trip_d = 1'b1;
    end
  end
`else
  logic unused_wd_limit;
  assign unused_wd_limit = ^WATCHDOG_LIMIT;
  assign wd_fire         = 1'b0;
  assign watchdog_trip   = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    seen_busy_d = seen_busy_q;
    ext_d       = ext_q;
    round_d     = round_q;
    unique case (state_q)
      StIdle: begin
        if (ap_start) state_d = StStart;
      end
      StStart: begin
        seen_busy_d = 1'b0;
        ext_d       = 1'b0;
        round_d     = '0;
        state_d     = StRun;
      end
      StRun: begin
        if (!(&actor_ap_idle)) seen_busy_d = 1'b1;
        // A write coinciding with a sync round must survive the clear.
        if (all_sync) ext_d = 1'b0;
        if (|in_fifo_write) ext_d = 1'b1;
        if (sync_rise && (round_q != 16'hffff)) round_d = round_q + 16'd1;
        if ((seen_busy_q && (&actor_ap_idle)) || wd_fire) state_d = StFinish;
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= StIdle;
      seen_busy_q <= 1'b0;
      ext_q       <= 1'b0;
      sync_prev_q <= 1'b0;
      round_q     <= '0;
`ifdef NETWORK_BARRIER_WATCHDOG_EN
      wd_cnt_q    <= '0;
      trip_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      seen_busy_q <= seen_busy_d;
      ext_q       <= ext_d;
      sync_prev_q <= all_sync;
      round_q     <= round_d;
`ifdef NETWORK_BARRIER_WATCHDOG_EN
      wd_cnt_q    <= wd_cnt_d;
      trip_q      <= trip_d;
`endif
    end
  end

endmodule
